// File: rtl/mux_recirc_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : mux_recirc_tx_sched
// Brief    : Round-robin source-side scheduler for a shared mux-recirculation
//            CDC channel; stretches EN and holds A quiet after each transfer.
// Revision : 1.0
// ============================================================================
module mux_recirc_tx_sched #(
    parameter int NREQ        = 4,
    parameter int DW          = 2,
    parameter int EN_CYCLES   = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 c1,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [DW-1:0]        A,
    output logic                 EN,
    output logic                 busy
);

    localparam int c_max_cnt = (EN_CYCLES > HOLD_CYCLES) ? EN_CYCLES : HOLD_CYCLES;
    localparam int c_cnt_w   = $clog2(c_max_cnt + 1);
    localparam int c_ptr_w   = $clog2(NREQ);

    localparam logic [c_cnt_w-1:0] c_en_load   = c_cnt_w'(EN_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_ptr_w-1:0] c_last_rst  = c_ptr_w'(NREQ - 1);

    generate
        if (NREQ < 2) begin : g_chk_nreq
            $error("mux_recirc_tx_sched: NREQ must be >= 2");
        end
        if (EN_CYCLES < 1) begin : g_chk_en
            $error("mux_recirc_tx_sched: EN_CYCLES must be >= 1");
        end
        if (HOLD_CYCLES < 1) begin : g_chk_hold
            $error("mux_recirc_tx_sched: HOLD_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_ptr_w-1:0]   r_last;
    logic [NREQ-1:0]      r_gnt;
    logic [DW-1:0]        r_a;
    logic                 r_en;
    logic                 r_busy;

    logic                 w_found;
    logic [c_ptr_w-1:0]   w_sel;

    // Search starts just past the last winner so it drops to lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_found && req[(int'(r_last) + i) % NREQ]) begin
                w_found = 1'b1;
                w_sel   = c_ptr_w'((int'(r_last) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge c1 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= c_last_rst;
            r_gnt   <= '0;
            r_a     <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a     <= req_data[int'(w_sel)*DW +: DW];
                        r_en    <= 1'b1;
                        r_gnt   <= NREQ'(1) << w_sel;
                        r_last  <= w_sel;
                        r_cnt   <= c_en_load;
                        r_state <= S_SEND;
                        r_busy  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (r_cnt == '0) begin
                        r_en    <= 1'b0;
                        r_cnt   <= c_hold_load;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                S_HOLD: begin
                    // A stays put here so the destination samples settled data.
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign A    = r_a;
    assign EN   = r_en;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux_recirc_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_recirc_tx_sched
// Brief    : Directed, table-driven self-checking bench for mux_recirc_tx_sched.
// Revision : 1.0
// ============================================================================
module tb_mux_recirc_tx_sched;

    logic       c1;
    logic       rst;
    logic [3:0] req;
    logic [7:0] req_data;
    logic [3:0] gnt;
    logic [1:0] A;
    logic       EN;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0] req;
        logic [7:0] data;
        logic [3:0] exp_gnt;
        logic [1:0] exp_a;
    } vec_t;

    vec_t vecs[8];

    mux_recirc_tx_sched #(
        .NREQ(4), .DW(2), .EN_CYCLES(2), .HOLD_CYCLES(4)
    ) dut (
        .c1(c1), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .A(A), .EN(EN), .busy(busy)
    );

    initial c1 = 1'b0;
    always #5 c1 = ~c1;
    always @(posedge c1) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge c1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Bounded wait for the next grant pulse; returns cycles waited.
    task automatic wait_gnt(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (gnt == 4'b0 && n < limit);
    endtask

    // One full transfer from IDLE: grant, 2 EN cycles, 4 HOLD cycles, back to IDLE.
    task automatic run_txn(input logic [3:0] r, input logic [7:0] d,
                           input logic [3:0] eg, input logic [1:0] ea);
        int n;
        req      = r;
        req_data = d;
        wait_gnt(4, n);
        chk("txn_latency", n, 1);
        chk("txn_gnt", gnt, eg);
        chk("txn_A_grant", A, ea);
        chk("txn_EN_1", EN, 1);
        chk("txn_busy_1", busy, 1);
        req = 4'b0;
        step();
        chk("txn_gnt_pulse", gnt, 0);
        chk("txn_EN_2", EN, 1);
        chk("txn_A_send", A, ea);
        for (int h = 0; h < 4; h++) begin
            step();
            chk("txn_EN_hold", EN, 0);
            chk("txn_A_hold", A, ea);
            chk("txn_busy_hold", busy, 1);
        end
        step();
        chk("txn_busy_idle", busy, 0);
        chk("txn_EN_idle", EN, 0);
        chk("txn_A_idle", A, ea);
        chk("txn_gnt_idle", gnt, 0);
    endtask

    initial begin
        int n;
        int tprev;
        logic [3:0] rr_gnt[5];
        logic [1:0] rr_a[5];

        // Pointer chains from reset (last=3); slice i sits at bits [2i+:2].
        vecs[0] = '{4'b0100, 8'h30, 4'b0100, 2'd3};
        vecs[1] = '{4'b1111, 8'hE4, 4'b1000, 2'd3};
        vecs[2] = '{4'b1111, 8'hE4, 4'b0001, 2'd0};
        vecs[3] = '{4'b0110, 8'h18, 4'b0010, 2'd2};
        vecs[4] = '{4'b0011, 8'h0D, 4'b0001, 2'd1};
        vecs[5] = '{4'b1000, 8'h80, 4'b1000, 2'd2};
        vecs[6] = '{4'b1001, 8'hC1, 4'b0001, 2'd1};
        vecs[7] = '{4'b1001, 8'hC1, 4'b1000, 2'd3};
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_a   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst      = 1'b1;
        req      = 4'b0;
        req_data = 8'h0;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();

        // Reset mid-sim with req idle
        #3 rst = 1'b1;
        #1 chk("rst_outputs", {gnt, A, EN, busy}, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_after_rst", {gnt, A, EN, busy}, 0);
        end

        for (int v = 0; v < 8; v++)
            run_txn(vecs[v].req, vecs[v].data, vecs[v].exp_gnt, vecs[v].exp_a);

        // Round-robin with all requests held
        do_reset();
        req      = 4'b1111;
        req_data = 8'hE4;
        tprev    = 0;
        for (int j = 0; j < 5; j++) begin
            wait_gnt(10, n);
            if (j > 0) chk("rr_period", cyc - tprev, 7);
            tprev = cyc;
            chk("rr_gnt", gnt, rr_gnt[j]);
            chk("rr_A", A, rr_a[j]);
        end
        req = 4'b0;
        repeat (8) step();

        // Late request arriving during HOLD is ignored until IDLE
        do_reset();
        req      = 4'b0001;
        req_data = 8'h01;
        wait_gnt(4, n);
        chk("late_gnt0", gnt, 4'b0001);
        req = 4'b0;
        step();
        step();
        req      = 4'b0010;
        req_data = 8'h0B;
        chk("late_hold_EN", EN, 0);
        chk("late_hold_A", A, 1);
        for (int h = 0; h < 3; h++) begin
            step();
            chk("late_hold_EN", EN, 0);
            chk("late_hold_A", A, 1);
            chk("late_hold_gnt", gnt, 0);
        end
        step();
        chk("late_idle_gnt", gnt, 0);
        chk("late_idle_busy", busy, 0);
        step();
        chk("late_gnt1", gnt, 4'b0010);
        chk("late_A1", A, 2);
        chk("late_EN1", EN, 1);
        req = 4'b0;
        repeat (7) step();

        // Asynchronous reset in the second EN cycle
        do_reset();
        req      = 4'b0001;
        req_data = 8'h02;
        wait_gnt(4, n);
        chk("mid_gnt", gnt, 4'b0001);
        chk("mid_A", A, 2);
        req = 4'b0;
        step();
        chk("mid_EN2", EN, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_EN", EN, 0);
        chk("mid_rst_A", A, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        run_txn(4'b0010, 8'h0C, 4'b0010, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
